sample_player: RTL and testbench
================================

SAMPLE_PLAYER -- requirements
Module: sample_player

Interface
REQ-001 Parameter DATA_W, default 8, sample width in bits.
REQ-002 Parameter NUM_CH, default 1, channels per beat; beat width is NUM_CH*DATA_W.
REQ-003 Parameter DEPTH, default 1500, number of beats stored.
REQ-004 Parameter ADDR_W, default 11, address width; DEPTH SHALL be at most 2**ADDR_W.
REQ-005 Port list, clock and reset first:
  - clk  in  1  rising-edge clock.
  - rst  in  1  asynchronous, active-high reset.
  - start  in  1  one-cycle pulse that begins playback.
  - stop  in  1  one-cycle pulse that aborts playback.
  - loop_en  in  1  1 = wrap continuously, 0 = play once; sampled at start.
  - len  in  ADDR_W+1  number of beats to play; sampled at start; 0 means DEPTH.
  - wr_en  in  1  memory load strobe.
  - wr_addr  in  ADDR_W  memory load address.
  - wr_data  in  NUM_CH*DATA_W  memory load data; channel 0 in the LSBs.
  - out_ready  in  1  downstream ready.
  - out_valid  out  1  beat valid.
  - out_data  out  NUM_CH*DATA_W  beat data.
  - out_last  out  1  final beat of a pass.
  - busy  out  1  FSM not IDLE.
  - done  out  1  one-cycle completion pulse.

Function
REQ-006 Storage SHALL be a DEPTH x (NUM_CH*DATA_W) register array with asynchronous read and synchronous write.
REQ-007 wr_en SHALL write only while busy=0; writes while busy=1 and writes with wr_addr>=DEPTH SHALL be ignored.
REQ-008 The FSM SHALL have three states:
  - IDLE: start -> RUN.
  - RUN: pass complete with loop_en=0, or stop -> DRAIN.
  - DRAIN: pending beat accepted or none pending -> IDLE and done=1 for one cycle.
REQ-009 On start in IDLE, the block SHALL latch len and loop_en and set rd_ptr=0; out_valid SHALL rise the next cycle with out_data=mem[0].
REQ-010 The output register SHALL load mem[rd_ptr] when (out_valid=0 or out_ready=1) and the FSM is in RUN; rd_ptr SHALL then increment.
REQ-011 Throughput SHALL be one beat per cycle while out_ready=1.
REQ-012 out_valid, out_data and out_last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-013 out_last SHALL be 1 on the beat read from address len-1.
REQ-014 With loop_en=1, rd_ptr SHALL wrap from len-1 to 0 without a bubble, and out_last SHALL repeat each pass.
REQ-015 With loop_en=0, no beat SHALL be loaded after address len-1.
REQ-016 stop in RUN SHALL prevent new loads; a beat already valid SHALL complete its handshake before IDLE.
REQ-017 start while busy=1 SHALL be ignored.
REQ-018 start and stop in the same cycle in IDLE: stop SHALL win and the block SHALL remain IDLE.
REQ-019 len greater than DEPTH SHALL be clamped to DEPTH.
REQ-020 len=1 SHALL produce a single beat with out_last=1.

Reset
REQ-021 rst SHALL force IDLE with out_valid=0, out_last=0, out_data=0, busy=0, done=0, rd_ptr=0.
REQ-022 Memory contents SHALL NOT be cleared by rst.
REQ-023 rst asserted mid-playback SHALL drop out_valid immediately, with no done pulse.

Structure
REQ-024 FSM state encoding and the default DATA_W/DEPTH/ADDR_W constants SHALL live in the shared package sample_player_pkg.
REQ-025 Storage SHALL be one sub-module, sample_mem (write port plus asynchronous read port); FSM and output register SHALL be in sample_player.

Verification
REQ-026 Load mem[i]=i[7:0] for i=0..1499; start, len=0, loop_en=0, out_ready=1 -> 1500 beats 0x00..0xDB in order, out_last on 0xDB (i=1499), done one cycle later.
REQ-027 len=4, loop_en=1, out_ready=1 -> data 0,1,2,3,0,1,... with out_last on every 3 and no gap.
REQ-028 len=8, out_ready toggled 1,0,0,1 repeating -> data held stable while stalled; all 8 beats delivered exactly once.
REQ-029 stop at the third beat with out_ready=0 -> beat 2 held until out_ready=1, then IDLE and done; no beat 3.
REQ-030 NUM_CH=2, DATA_W=12: load {ch1,ch0}={0x123,0x456}; start len=1 -> out_data=0x123456, out_last=1.
REQ-031 rst pulse mid-stream, then start len=2 -> out_valid=0 right after rst, restart from mem[0], memory intact.

Source files
------------

// File: rtl/sample_player_pkg.sv
// sample_player_pkg: shared FSM encoding and default geometry for the sample player
package sample_player_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 1500;
    localparam int DEF_ADDR_W = 11;
endpackage

// File: rtl/sample_mem.sv
// sample_mem: beat storage with synchronous write and asynchronous read, no reset
module sample_mem
    import sample_player_pkg::*;
#(
    parameter int WIDTH  = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);
    localparam logic [ADDR_W:0] LIM = (ADDR_W+1)'(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    // write only in-range addresses; contents survive reset
    always_ff @(posedge clk)
        if (we && {1'b0, waddr} < LIM) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/sample_player.sv
// sample_player: plays stored beats out over a valid/ready stream, once or looping
module sample_player
    import sample_player_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NUM_CH = 1,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     loop_en,
    input  logic [ADDR_W:0]          len,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [NUM_CH*DATA_W-1:0] wr_data,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done
);
    localparam int W = NUM_CH * DATA_W;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    state_t            state, state_n;
    logic [ADDR_W-1:0] rd_ptr, raddr;
    logic [ADDR_W:0]   len_q, len_c, cur_len;
    logic              loop_q, cur_loop, go, load, fin, at_last;
    logic [W-1:0]      rd_data;

    // the start cycle itself loads mem[0], so the first beat appears one cycle after start
    assign busy     = state != IDLE;
    assign go       = state == IDLE && start && !stop;
    assign len_c    = (len == '0 || len > DEPTH_L) ? DEPTH_L : len;
    assign cur_len  = go ? len_c : len_q;
    assign cur_loop = go ? loop_en : loop_q;
    assign raddr    = go ? '0 : rd_ptr;
    assign at_last  = {1'b0, raddr} == cur_len - 1'b1;

    sample_mem #(.WIDTH(W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
        .clk   (clk),
        .we    (wr_en && !busy),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (raddr),
        .rdata (rd_data)
    );

    // state register
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_n;

    // next state, output-register load strobe and completion strobe
    always_comb begin
        state_n = state;
        load    = 1'b0;
        fin     = 1'b0;
        case (state)
            IDLE: if (go) begin
                load    = 1'b1;
                state_n = (at_last && !cur_loop) ? DRAIN : RUN;
            end
            RUN: if (stop) state_n = DRAIN;
                 else if (!out_valid || out_ready) begin
                     load    = 1'b1;
                     state_n = (at_last && !cur_loop) ? DRAIN : RUN;
                 end
            DRAIN: if (!out_valid || out_ready) begin
                fin     = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // playback settings, read pointer and output register
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            len_q     <= '0;
            loop_q    <= 1'b0;
            rd_ptr    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done      <= fin;
            out_valid <= load | (out_valid & ~out_ready);
            if (go) begin
                len_q  <= len_c;
                loop_q <= loop_en;
            end
            if (load) begin
                out_data <= rd_data;
                out_last <= at_last;
                rd_ptr   <= at_last ? '0 : raddr + 1'b1;
            end
        end
endmodule

// File: tb/tb_sample_player.sv
// tb_sample_player: directed checks of the sample player against hand-computed values
module tb_sample_player;
    logic        clk = 1'b0, rst = 1'b1;
    logic        start = 0, stop = 0, loop_en = 0, wr_en = 0, out_ready = 0;
    logic [11:0] len = '0;
    logic [10:0] wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic        out_valid, out_last, busy, done;
    logic [7:0]  out_data;
    logic        start2 = 0, wr_en2 = 0;
    logic [23:0] wr_data2 = '0, od2;
    logic        ov2, ol2, busy2, done2;
    int total = 0, bad = 0, acc, seen;

    always #5 clk = ~clk;

    sample_player dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .loop_en(loop_en), .len(len),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .out_ready(out_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .busy(busy), .done(done)
    );

    sample_player #(.DATA_W(12), .NUM_CH(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .stop(stop), .loop_en(loop_en), .len(len),
        .wr_en(wr_en2), .wr_addr(wr_addr), .wr_data(wr_data2), .out_ready(out_ready),
        .out_valid(ov2), .out_data(od2), .out_last(ol2), .busy(busy2), .done(done2)
    );

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, o, e);
        end
    endtask

    initial begin
        @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst = 0;
        // two-channel instance: single beat
        wr_en2 = 1; wr_addr = 0; wr_data2 = 24'h123456;
        @(negedge clk);
        wr_en2 = 0; start2 = 1; len = 1; loop_en = 0; out_ready = 1;
        @(negedge clk);
        start2 = 0;
        chk("ch2_valid", ov2, 1);
        chk("ch2_data", od2, 32'h123456);
        chk("ch2_last", ol2, 1);
        @(negedge clk);
        chk("ch2_done", done2, 1);
        // load ramp
        for (int i = 0; i < 1500; i++) begin
            wr_en = 1; wr_addr = 11'(i); wr_data = 8'(i);
            @(negedge clk);
        end
        wr_en = 0;
        // full play once, len=0 means DEPTH
        start = 1; len = 0; loop_en = 0; out_ready = 1;
        @(negedge clk);
        start = 0;
        chk("full_busy", busy, 1);
        for (int i = 0; i < 1500; i++) begin
            chk("full_valid", out_valid, 1);
            chk("full_data", out_data, i & 255);
            chk("full_last", out_last, 32'(i == 1499));
            @(negedge clk);
        end
        chk("full_end_valid", out_valid, 0);
        chk("full_done", done, 1);
        chk("full_idle", busy, 0);
        @(negedge clk);
        chk("full_done_pulse", done, 0);
        // loop len=4, ignored restart and ignored write while busy
        start = 1; len = 4; loop_en = 1;
        @(negedge clk);
        start = 0;
        for (int k = 0; k < 12; k++) begin
            chk("loop_valid", out_valid, 1);
            chk("loop_data", out_data, k % 4);
            chk("loop_last", out_last, 32'(k % 4 == 3));
            start = (k == 5); len = (k == 5) ? 12'd2 : 12'd4;
            wr_en = (k == 5); wr_addr = 0; wr_data = 8'hAA;
            stop = (k == 11);
            @(negedge clk);
        end
        stop = 0; wr_en = 0;
        chk("loop_stop_valid", out_valid, 0);
        chk("loop_stop_busy", busy, 1);
        @(negedge clk);
        chk("loop_stop_done", done, 1);
        chk("loop_stop_idle", busy, 0);
        // stalled stream, ready 1,0,0,1
        start = 1; len = 8; loop_en = 0; out_ready = 1;
        @(negedge clk);
        start = 0; acc = 0; seen = 0;
        for (int c = 0; c < 60 && seen == 0; c++) begin
            if (done) seen = 1;
            else begin
                out_ready = (c % 4 == 0) || (c % 4 == 3);
                if (out_valid) begin
                    chk("stall_data", out_data, acc);
                    chk("stall_last", out_last, 32'(acc == 7));
                    if (out_ready) acc++;
                end
                @(negedge clk);
            end
        end
        chk("stall_count", acc, 8);
        chk("stall_done_seen", seen, 1);
        out_ready = 1;
        @(negedge clk);
        // stop at third beat while stalled
        start = 1; len = 8;
        @(negedge clk);
        start = 0;
        chk("stop_b0", out_data, 0);
        @(negedge clk);
        chk("stop_b1", out_data, 1);
        @(negedge clk);
        chk("stop_b2", out_data, 2);
        out_ready = 0; stop = 1;
        @(negedge clk);
        stop = 0;
        chk("stop_hold_valid", out_valid, 1);
        chk("stop_hold_data", out_data, 2);
        @(negedge clk);
        chk("stop_hold2_data", out_data, 2);
        chk("stop_hold_done", done, 0);
        out_ready = 1;
        @(negedge clk);
        chk("stop_end_valid", out_valid, 0);
        chk("stop_done", done, 1);
        chk("stop_idle", busy, 0);
        @(negedge clk);
        chk("stop_no_b3", out_valid, 0);
        // start and stop together in IDLE
        start = 1; stop = 1; len = 4;
        @(negedge clk);
        start = 0; stop = 0;
        chk("both_busy", busy, 0);
        chk("both_valid", out_valid, 0);
        @(negedge clk);
        // len=1
        start = 1; len = 1;
        @(negedge clk);
        start = 0;
        chk("one_valid", out_valid, 1);
        chk("one_last", out_last, 1);
        chk("one_data", out_data, 0);
        @(negedge clk);
        chk("one_end", out_valid, 0);
        chk("one_done", done, 1);
        // oversize len clamps to DEPTH while looping
        start = 1; len = 12'd4095; loop_en = 1;
        @(negedge clk);
        start = 0;
        for (int k = 0; k < 1502; k++) begin
            chk("clamp_data", out_data, (k % 1500) & 255);
            chk("clamp_last", out_last, 32'(k % 1500 == 1499));
            stop = (k == 1501);
            @(negedge clk);
        end
        stop = 0;
        @(negedge clk);
        chk("clamp_done", done, 1);
        loop_en = 0;
        // reset mid-stream
        start = 1; len = 8;
        @(negedge clk);
        start = 0;
        @(negedge clk);
        chk("rst_mid_b1", out_data, 1);
        rst = 1;
        #1;
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_busy", busy, 0);
        @(negedge clk);
        chk("rst_mid_done", done, 0);
        rst = 0;
        @(negedge clk);
        start = 1; len = 2;
        @(negedge clk);
        start = 0;
        chk("restart_b0", out_data, 0);
        chk("restart_l0", out_last, 0);
        @(negedge clk);
        chk("restart_b1", out_data, 1);
        chk("restart_l1", out_last, 1);
        @(negedge clk);
        chk("restart_done", done, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
